// File: rtl/regfile_dump.sv
// regfile_dump: walks the register file through one read port and streams (index, value) beats over valid/ready; ports clk, rst, start, rf_addr/rf_data (read port), out_valid/out_ready/out_idx/out_data (beat stream), busy, dump_done
module regfile_dump #(
  parameter int NREGS   = 32,
  parameter int AW      = 5,
  parameter int DW      = 32,
  parameter bit SKIP_X0 = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [AW-1:0] rf_addr,
  input  logic [DW-1:0] rf_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_idx,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          dump_done
);
  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;
  state_t state;
  logic [AW-1:0] idx;
  assign rf_addr = idx;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      out_idx   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      dump_done <= 1'b0;
    end else begin
      dump_done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          idx   <= SKIP_X0 ? AW'(1) : AW'(0);
          busy  <= 1'b1;
          state <= READ;
        end
        READ: begin
          out_data  <= rf_data;
          out_idx   <= idx;
          out_valid <= 1'b1;
          state     <= SEND;
        end
        SEND: if (out_ready) begin
          out_valid <= 1'b0;
          if (idx == AW'(NREGS - 1)) begin
            dump_done <= 1'b1;
            state     <= DONE;
          end else begin
            idx   <= idx + AW'(1);
            state <= READ;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          idx   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: randomized bench for regfile_dump against a queue-based model of the expected beat stream
module tb_regfile_dump;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, start = 1'b0, out_ready = 1'b1, rnd = 1'b0, chk_on = 1'b0;
  logic [4:0] rf_addr, out_idx;
  logic [31:0] rf_data, out_data;
  logic out_valid, busy, dump_done;
  logic start1 = 1'b0;
  logic [4:0] rf_addr1, out_idx1;
  logic [31:0] rf_data1, out_data1;
  logic out_valid1, busy1, dump_done1;
  logic [31:0] rf [32];
  assign rf_data  = (rf_addr == 5'd0) ? 32'd0 : rf[rf_addr];
  assign rf_data1 = (rf_addr1 == 5'd0) ? 32'd0 : rf[rf_addr1];
  regfile_dump dut (.clk(clk), .rst(rst), .start(start), .rf_addr(rf_addr), .rf_data(rf_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_data(out_data),
    .busy(busy), .dump_done(dump_done));
  regfile_dump #(.SKIP_X0(1'b1)) dut1 (.clk(clk), .rst(rst), .start(start1), .rf_addr(rf_addr1),
    .rf_data(rf_data1), .out_valid(out_valid1), .out_ready(1'b1), .out_idx(out_idx1),
    .out_data(out_data1), .busy(busy1), .dump_done(dump_done1));
  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, a, e, $time);
    end
  endtask
  // model state: beats still owed, and the timing rules that must hold next cycle
  int qi[$];
  logic [31:0] qd[$];
  logic busy_exp = 1'b0, done_exp = 1'b0, was_rst = 1'b0, hold = 1'b0;
  logic [4:0] hidx;
  logic [31:0] hdata;
  int vdue = 0, ngot = 0, ndone = 0;
  logic [31:0] got [32];
  always @(posedge clk) begin
    #1;
    out_ready = rnd ? 1'($urandom_range(1)) : 1'b1;
  end
  always @(negedge clk) begin
    if (chk_on) begin
      logic acc, last, st;
      if (was_rst) begin
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_addr", 32'(rf_addr), 0);
        chk("rst_done", 32'(dump_done), 0);
        chk("rst_idx", 32'(out_idx), 0);
        chk("rst_data", out_data, 0);
      end else begin
        chk("busy", 32'(busy), 32'(busy_exp));
        chk("dump_done", 32'(dump_done), 32'(done_exp));
        if (hold) begin
          chk("hold_valid", 32'(out_valid), 1);
          chk("hold_idx", 32'(out_idx), 32'(hidx));
          chk("hold_data", out_data, hdata);
        end
        if (vdue == 2) chk("gap_valid", 32'(out_valid), 0);
        else if (vdue == 1) chk("latency_valid", 32'(out_valid), 1);
        if (!busy_exp) chk("idle_valid", 32'(out_valid), 0);
        if (out_valid) chk("rf_addr", 32'(rf_addr), 32'(out_idx));
      end
      if (dump_done) ndone++;
      acc = out_valid && out_ready && !rst;
      st = start && !busy_exp && !rst;
      last = 1'b0;
      if (acc) begin
        if (qi.size() == 0) chk("extra_beat", 32'(out_idx), 32'hffffffff);
        else begin
          chk("beat_idx", 32'(out_idx), 32'(qi[0]));
          chk("beat_data", out_data, qd[0]);
          void'(qi.pop_front());
          void'(qd.pop_front());
          last = (qi.size() == 0);
        end
        got[out_idx] = out_data;
        ngot++;
      end
      hold = out_valid && !out_ready && !rst;
      hidx = out_idx;
      hdata = out_data;
      vdue = rst ? 0 : st ? 2 : (vdue == 2) ? 1 : (acc && !last) ? 2 : 0;
      busy_exp = rst ? 1'b0 : st ? 1'b1 : done_exp ? 1'b0 : busy_exp;
      done_exp = last && !rst;
      if (st) begin
        qi.delete();
        qd.delete();
        for (int i = 0; i < 32; i++) begin
          qi.push_back(i);
          qd.push_back(i == 0 ? 32'd0 : rf[i]);
        end
      end
      if (rst) begin
        qi.delete();
        qd.delete();
      end
      was_rst = rst;
    end
  end
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask
  task automatic wait_done(input int n0, input int lim);
    int c = 0;
    while (ndone == n0 && c < lim) begin
      @(posedge clk);
      c++;
    end
    chk("done_seen", 32'(ndone - n0), 1);
    repeat (4) @(posedge clk);
  endtask
  initial begin
    int n0, d0, first_c, e, nd1;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'd0;
    rf[1] = 32'h12345678;
    rf[2] = 32'h87654321;
    @(posedge clk); #1 chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    // T1
    n0 = ngot; d0 = ndone;
    pulse_start();
    wait_done(d0, 200);
    chk("t1_beats", 32'(ngot - n0), 32);
    chk("t1_beat0", got[0], 32'h0);
    chk("t1_beat1", got[1], 32'h12345678);
    chk("t1_beat2", got[2], 32'h87654321);
    chk("t1_ndone", 32'(ndone - d0), 1);
    // T2
    rf[0] = 32'hDEADBEEF;
    n0 = ngot; d0 = ndone;
    pulse_start();
    wait_done(d0, 200);
    chk("t2_x0", got[0], 32'h0);
    chk("t2_beats", 32'(ngot - n0), 32);
    // T3
    rnd = 1'b1;
    n0 = ngot; d0 = ndone;
    pulse_start();
    wait_done(d0, 600);
    chk("t3_beats", 32'(ngot - n0), 32);
    chk("t3_beat31", got[31], rf[31]);
    // T4
    n0 = ngot; d0 = ndone;
    pulse_start();
    for (int c = 0; c < 300 && ngot - n0 < 5; c++) @(posedge clk);
    pulse_start();
    wait_done(d0, 600);
    repeat (20) @(posedge clk);
    chk("t4_beats", 32'(ngot - n0), 32);
    chk("t4_ndone", 32'(ndone - d0), 1);
    // T5
    rnd = 1'b0;
    n0 = ngot; d0 = ndone;
    pulse_start();
    for (int c = 0; c < 300 && ngot - n0 < 10; c++) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    chk("t5_no_done", 32'(ndone - d0), 0);
    chk("t5_partial", 32'(ngot - n0 < 32), 1);
    n0 = ngot;
    pulse_start();
    wait_done(d0, 200);
    chk("t5_beats", 32'(ngot - n0), 32);
    // T6
    first_c = -1; e = 1; nd1 = 0;
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (out_valid1) begin
        if (first_c < 0) first_c = c;
        chk("t6_idx", 32'(out_idx1), 32'(e));
        chk("t6_data", out_data1, rf[e & 31]);
        e++;
      end
      if (dump_done1) nd1++;
    end
    chk("t6_latency", 32'(first_c), 1);
    chk("t6_count", 32'(e), 32);
    chk("t6_ndone", 32'(nd1), 1);
    chk("t6_busy", 32'(busy1), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
